// File: rtl/fnd_scan_ctrl.sv
// Scan controller for an 8-digit seven-segment display.
// It steps the digit mux select, decodes the sampled nibble and drives
// active-low commons, with a dark blanking gap before each digit.
module fnd_scan_ctrl #(
  parameter int SCAN_DIV   = 100_000,
  parameter int BLANK_CYC  = 1_000,
  parameter int NUM_DIGITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] mux_y,
  input  logic [7:0] dp_mask,
  input  logic [7:0] blank_mask,
  output logic [2:0] sel,
  output logic [7:0] fnd_com,
  output logic [7:0] fnd_font,
  output logic       frame_done
);

  localparam int SHOW_CYC = SCAN_DIV - BLANK_CYC;
  localparam int CW       = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    lit_com;
  logic [7:0]    lit_font;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // What the pins should show for the currently selected digit; a masked digit stays dark.
  always_comb begin
    lit_com  = 8'hFF;
    lit_font = 8'hFF;
    if (!blank_mask[sel]) begin
      lit_com  = ~(8'h01 << sel);
      lit_font = {~dp_mask[sel], decode(mux_y)};
    end
  end

  // The last BLANK edge already loads the digit, so a slot is BLANK_CYC dark plus SHOW_CYC lit cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= 3'd0;
      cnt        <= '0;
      fnd_com    <= 8'hFF;
      fnd_font   <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        sel      <= 3'd0;
        cnt      <= '0;
        fnd_com  <= 8'hFF;
        fnd_font <= 8'hFF;
      end else begin
        case (state)
          IDLE: begin
            state    <= BLANK;
            cnt      <= '0;
            fnd_com  <= 8'hFF;
            fnd_font <= 8'hFF;
          end
          BLANK: begin
            if (cnt == CW'(BLANK_CYC - 1)) begin
              state    <= SHOW;
              cnt      <= '0;
              fnd_com  <= lit_com;
              fnd_font <= lit_font;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHOW: begin
            if (cnt == CW'(SHOW_CYC - 1)) begin
              state    <= BLANK;
              cnt      <= '0;
              fnd_com  <= 8'hFF;
              fnd_font <= 8'hFF;
              if (sel == 3'(NUM_DIGITS - 1)) begin
                sel        <= 3'd0;
                frame_done <= 1'b1;
              end else begin
                sel <= sel + 3'd1;
              end
            end else begin
              cnt      <= cnt + 1'b1;
              fnd_com  <= lit_com;
              fnd_font <= lit_font;
            end
          end
          default: begin
            state    <= IDLE;
            sel      <= 3'd0;
            cnt      <= '0;
            fnd_com  <= 8'hFF;
            fnd_font <= 8'hFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl with a 10-cycle slot, 2 blank cycles and 4 digits.
// A slot-position model predicts every output each cycle.
module tb_fnd_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [3:0] mux_y;
  logic [7:0] dp_mask = 8'h00;
  logic [7:0] blank_mask = 8'h00;
  logic [2:0] sel;
  logic [7:0] fnd_com;
  logic [7:0] fnd_font;
  logic       frame_done;

  logic       ovr = 1'b0;
  logic [3:0] force_y = 4'h0;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] com;
    logic [7:0] font;
    logic       fd;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  bit   active = 1'b0;
  int   k = 0;
  int   pulses = 0;
  int   first_k = -1;
  int   gap = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  assign mux_y = ovr ? force_y : (4'(sel) + 4'd5);

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.SCAN_DIV(10), .BLANK_CYC(2), .NUM_DIGITS(4)) dut (
    .clk(clk), .reset(reset), .en(en), .mux_y(mux_y), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .sel(sel), .fnd_com(fnd_com), .fnd_font(fnd_font),
    .frame_done(frame_done)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge: predict from slot position k, queue it, then compare.
  task automatic applyStimulus();
    exp_t       e;
    int         d;
    logic [3:0] y;
    @(posedge clk);
    if (reset || !en) begin
      active = 1'b0;
      k = 0;
    end else if (!active) begin
      active = 1'b1;
      k = 0;
    end else begin
      k++;
    end
    e = '{sel: 3'd0, com: 8'hFF, font: 8'hFF, fd: 1'b0};
    if (active) begin
      d = (k / 10) % 4;
      e.sel = 3'(d);
      e.fd = (k > 0) && (k % 40 == 0);
      if ((k % 10) >= 2 && !blank_mask[d]) begin
        y = ovr ? force_y : 4'(d + 5);
        e.com = ~(8'h01 << d);
        e.font = {~dp_mask[d], seg_tab[y]};
      end
    end
    sbq.push_back(e);
    #1;
    e = sbq.pop_front();
    checkOutput("sel", {5'b0, sel}, {5'b0, e.sel});
    checkOutput("fnd_com", fnd_com, e.com);
    checkOutput("fnd_font", fnd_font, e.font);
    checkOutput("frame_done", {7'b0, frame_done}, {7'b0, e.fd});
    tests++;
    assert ($countones(~fnd_com) <= 1) else begin
      fails++;
      $error("FAIL one_common: got fnd_com %h, expected at most one low bit", fnd_com);
    end
  endtask

  task automatic waitPhase(input int lo, input int hi);
    int guard = 0;
    while (!(active && (k % 40) >= lo && (k % 40) <= hi) && guard < 200) begin
      applyStimulus();
      guard++;
    end
    tests++;
    assert (guard < 200) else begin
      fails++;
      $error("FAIL wait_phase: got timeout, expected phase %0d..%0d", lo, hi);
    end
  endtask

  initial begin
    repeat (2) applyStimulus();
    reset = 1'b0;
    en = 1'b1;

    // Startup: two dark cycles, then digits 0..3 and wrap
    repeat (45) applyStimulus();

    // Asynchronous reset in the middle of digit 2's lit phase
    waitPhase(25, 25);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_sel", {5'b0, sel}, 8'h00);
    checkOutput("rst_com", fnd_com, 8'hFF);
    checkOutput("rst_font", fnd_font, 8'hFF);
    checkOutput("rst_fd", {7'b0, frame_done}, 8'h00);
    applyStimulus();
    reset = 1'b0;

    // Free run: frame_done every 40 cycles
    for (int i = 0; i < 100; i++) begin
      applyStimulus();
      if (frame_done === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k;
        else gap = k - first_k;
      end
    end
    checkOutput("fd_count", 8'(pulses), 8'd2);
    checkOutput("fd_first", 8'(first_k), 8'd40);
    checkOutput("fd_period", 8'(gap), 8'd40);

    // Decimal point on digit 1, digit 2 suppressed
    dp_mask = 8'h02;
    blank_mask = 8'h04;
    waitPhase(12, 12);
    checkOutput("dp_digit1", fnd_font, 8'h02);
    repeat (40) applyStimulus();
    dp_mask = 8'h00;
    blank_mask = 8'h00;

    // Disable during digit 3, then restart at digit 0
    waitPhase(35, 35);
    en = 1'b0;
    applyStimulus();
    en = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("restart_com", fnd_com, 8'hFE);

    // Every nibble through the decoder on digit 0
    ovr = 1'b1;
    for (int v = 0; v < 16; v++) begin
      waitPhase(1, 8);
      force_y = 4'(v);
      applyStimulus();
      checkOutput("decode", fnd_font, {1'b1, seg_tab[v]});
    end
    ovr = 1'b0;
    repeat (5) applyStimulus();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
